// File: rtl/du_host_link_if.sv
// du_host_link_if: signal bundle between du_host_link, the host sequencer, payload source and UART pair
// Ports (as seen from the master, i.e. du_host_link):
//   in  i_cmd_valid, i_cmd, i_tx_words, i_rx_words   command request from the sequencer
//   out o_busy, o_done, o_timeout                    transaction status
//   out o_pl_rd, o_pl_addr / in i_pl_data            payload word fetch, data one cycle after o_pl_rd
//   out o_tx_start, o_tx_data / in i_tx_done         UART Tx byte handshake
//   in  i_rx_data, i_rx_done                         UART Rx byte stream
//   out o_rsp_valid, o_rsp_word, o_rsp_idx           reassembled response words
interface du_host_link_if #(
  parameter int NB_UART_DATA = 8,
  parameter int NB_WORD = 32,
  parameter int NB_CNT = 10
);
  logic i_cmd_valid;
  logic [NB_UART_DATA-1:0] i_cmd;
  logic [NB_CNT-1:0] i_tx_words;
  logic [NB_CNT-1:0] i_rx_words;
  logic o_busy;
  logic o_pl_rd;
  logic [NB_CNT-1:0] o_pl_addr;
  logic [NB_WORD-1:0] i_pl_data;
  logic o_tx_start;
  logic [NB_UART_DATA-1:0] o_tx_data;
  logic i_tx_done;
  logic [NB_UART_DATA-1:0] i_rx_data;
  logic i_rx_done;
  logic o_rsp_valid;
  logic [NB_WORD-1:0] o_rsp_word;
  logic [NB_CNT-1:0] o_rsp_idx;
  logic o_done;
  logic o_timeout;
  modport master (
    input i_cmd_valid, i_cmd, i_tx_words, i_rx_words, i_pl_data, i_tx_done, i_rx_data, i_rx_done,
    output o_busy, o_pl_rd, o_pl_addr, o_tx_start, o_tx_data, o_rsp_valid, o_rsp_word, o_rsp_idx,
    o_done, o_timeout
  );
  modport slave (
    output i_cmd_valid, i_cmd, i_tx_words, i_rx_words, i_pl_data, i_tx_done, i_rx_data, i_rx_done,
    input o_busy, o_pl_rd, o_pl_addr, o_tx_start, o_tx_data, o_rsp_valid, o_rsp_word, o_rsp_idx,
    o_done, o_timeout
  );
endinterface

// File: rtl/du_host_link.sv
// du_host_link: host-side UART protocol engine sending a command byte, optional payload words and collecting response words
// Ports:
//   clk      in   clock, all state on rising edge
//   i_rst_n  in   asynchronous active-low reset, release synchronised internally
//   bus      du_host_link_if.master: command, payload fetch, UART Tx/Rx and response signals
module du_host_link #(
  parameter int NB_UART_DATA = 8,
  parameter int NB_WORD = 32,
  parameter int NB_CNT = 10,
  parameter int TIMEOUT_CYC = 100000
) (
  input logic clk,
  input logic i_rst_n,
  du_host_link_if.master bus
);
  localparam int NB_TMO = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [3:0] {IDLE, CMD, CMD_W, FETCH, LATCH, BYTE, BYTE_W, RECV, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] rst_sync;
  logic rst_n;
  logic [NB_UART_DATA-1:0] cmd;
  logic [NB_CNT-1:0] tx_words, rx_words, tx_idx, rx_idx, rsp_idx;
  logic [NB_WORD-1:0] shift, rsp_word;
  logic [1:0] byte_cnt;
  logic [NB_TMO-1:0] tmo_cnt;
  logic rsp_valid, timeout;
  logic word_end, tx_last, rx_last, tmo_hit;
  // Reset asserts immediately but releases two clocks later, clear of the clock edge
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  assign word_end = byte_cnt == 2'd3;
  assign tx_last = tx_idx + NB_CNT'(1) == tx_words;
  assign rx_last = rx_idx + NB_CNT'(1) == rx_words;
  assign tmo_hit = tmo_cnt == NB_TMO'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    bus.o_busy = state != IDLE;
    bus.o_tx_start = state == CMD || state == BYTE;
    bus.o_tx_data = state == CMD || state == CMD_W ? cmd :
                    state == BYTE || state == BYTE_W ? shift[NB_UART_DATA-1:0] : '0;
    bus.o_pl_rd = state == FETCH;
    bus.o_pl_addr = tx_idx;
    bus.o_done = state == DONE;
    bus.o_rsp_valid = rsp_valid;
    bus.o_rsp_word = rsp_word;
    bus.o_rsp_idx = rsp_idx;
    bus.o_timeout = timeout;
    case (state)
      IDLE: state_nx = bus.i_cmd_valid ? CMD : IDLE;
      CMD: state_nx = CMD_W;
      CMD_W: state_nx = !bus.i_tx_done ? CMD_W : |tx_words ? FETCH : |rx_words ? RECV : DONE;
      FETCH: state_nx = LATCH;
      LATCH: state_nx = BYTE;
      BYTE: state_nx = BYTE_W;
      BYTE_W: state_nx = !bus.i_tx_done ? BYTE_W : !word_end ? BYTE : !tx_last ? FETCH :
                         |rx_words ? RECV : DONE;
      // A silent link aborts straight to IDLE, dropping any partial word
      RECV: state_nx = bus.i_rx_done ? (word_end && rx_last ? DONE : RECV) : tmo_hit ? IDLE : RECV;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cmd <= '0;
      tx_words <= '0;
      rx_words <= '0;
      tx_idx <= '0;
      rx_idx <= '0;
      shift <= '0;
      byte_cnt <= '0;
      tmo_cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_word <= '0;
      rsp_idx <= '0;
      timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      timeout <= state == RECV && !bus.i_rx_done && tmo_hit;
      tmo_cnt <= state == RECV && !bus.i_rx_done ? tmo_cnt + NB_TMO'(1) : '0;
      case (state)
        IDLE: begin
          if (bus.i_cmd_valid) begin
            cmd <= bus.i_cmd;
            tx_words <= bus.i_tx_words;
            rx_words <= bus.i_rx_words;
          end
          tx_idx <= '0;
          rx_idx <= '0;
          byte_cnt <= '0;
          shift <= '0;
        end
        LATCH: begin
          shift <= bus.i_pl_data;
          byte_cnt <= '0;
        end
        BYTE_W: if (bus.i_tx_done) begin
          shift <= shift >> NB_UART_DATA;
          byte_cnt <= byte_cnt + 2'd1;
          if (word_end) tx_idx <= tx_idx + NB_CNT'(1);
        end
        // Bytes enter at the MSB end so the first received byte ends up in the low byte
        RECV: if (bus.i_rx_done) begin
          shift <= {bus.i_rx_data, shift[NB_WORD-1:NB_UART_DATA]};
          byte_cnt <= byte_cnt + 2'd1;
          if (word_end) begin
            rsp_valid <= 1'b1;
            rsp_word <= {bus.i_rx_data, shift[NB_WORD-1:NB_UART_DATA]};
            rsp_idx <= rx_idx;
            rx_idx <= rx_idx + NB_CNT'(1);
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_du_host_link.sv
// tb_du_host_link: table vectors, corner sequences and random transactions against a byte-stream model of du_host_link
module tb_du_host_link;
  localparam int TMO = 50;
  typedef struct {
    logic [7:0] cmd;
    int txw;
    int rxw;
    logic [31:0] pl0;
    logic [31:0] pl1;
    logic [63:0] rxb;
    int ntx;
    logic [71:0] stream;
    int nrsp;
    logic [31:0] rsp0;
    logic [31:0] rsp1;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  du_host_link_if #(.NB_UART_DATA(8), .NB_WORD(32), .NB_CNT(10)) bus ();
  du_host_link #(.NB_UART_DATA(8), .NB_WORD(32), .NB_CNT(10), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );
  int n_tests = 0, n_fail = 0;
  int cyc = 0, txd_cyc = 0, done_cyc = 0, done_cnt = 0, to_cnt = 0, cd = 0, tx_lat = 10, hold_err = 0;
  bit busy_tx = 0;
  logic [31:0] pl_mem [0:3];
  logic [7:0] tx_log[$], rx_src[$], exp_tx[$];
  logic [31:0] rsp_w[$], exp_rsp[$];
  logic [9:0] rsp_i[$], pl_a[$];
  vec_t vecs [5];
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  function automatic void check(string name, logic [71:0] act, logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  function automatic logic [71:0] outs();
    return {6'd0, bus.o_busy, bus.o_tx_start, bus.o_tx_data, bus.o_pl_rd, bus.o_pl_addr, bus.o_rsp_valid,
            bus.o_rsp_word, bus.o_rsp_idx, bus.o_done, bus.o_timeout};
  endfunction
  // UART Tx model: one byte at a time, done pulse tx_lat cycles after each start
  initial begin
    bus.i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.i_tx_done = 1'b0;
      if (!rst_n) begin
        cd = 0;
        busy_tx = 0;
      end else begin
        if (busy_tx && bus.o_tx_data !== tx_log[$]) hold_err++;
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            bus.i_tx_done = 1'b1;
            busy_tx = 0;
            txd_cyc = cyc;
          end
        end
        if (bus.o_tx_start) begin
          check("tx_one_in_flight", busy_tx, 0);
          tx_log.push_back(bus.o_tx_data);
          busy_tx = 1;
          cd = tx_lat;
        end
      end
    end
  end
  // Payload source and output monitor
  initial begin
    bus.i_pl_data = '0;
    forever begin
      @(negedge clk);
      if (bus.o_pl_rd) begin
        pl_a.push_back(bus.o_pl_addr);
        bus.i_pl_data = pl_mem[bus.o_pl_addr[1:0]];
      end
      if (bus.o_rsp_valid) begin
        rsp_w.push_back(bus.o_rsp_word);
        rsp_i.push_back(bus.o_rsp_idx);
      end
      if (bus.o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.o_timeout) to_cnt++;
    end
  end
  task automatic issue(input logic [7:0] c, input int txw, input int rxw);
    tx_log.delete();
    rsp_w.delete();
    rsp_i.delete();
    pl_a.delete();
    done_cnt = 0;
    to_cnt = 0;
    @(negedge clk);
    bus.i_cmd = c;
    bus.i_tx_words = 10'(txw);
    bus.i_rx_words = 10'(rxw);
    bus.i_cmd_valid = 1'b1;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
  endtask
  // Waits for the whole Tx stream; with noise, pokes ignored cmd requests and stray Rx bytes meanwhile
  task automatic wait_tx(input int nbytes, input bit noise);
    int n = 0;
    while (!(tx_log.size() == nbytes && !busy_tx) && n < 2000) begin
      @(negedge clk);
      n++;
      if (noise) begin
        bus.i_cmd_valid = n % 7 == 3;
        bus.i_cmd = 8'hEE;
        bus.i_rx_done = n % 5 == 2;
        bus.i_rx_data = 8'h99;
      end
    end
    bus.i_cmd_valid = 1'b0;
    bus.i_rx_done = 1'b0;
    check("tx_stream_wait", n < 2000, 1);
  endtask
  task automatic send_rx(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask
  task automatic run_txn(input logic [7:0] c, input int txw, input int rxw, input bit noise);
    int n = 0;
    issue(c, txw, rxw);
    wait_tx(1 + 4 * txw, noise);
    foreach (rx_src[i]) send_rx(rx_src[i], 2);
    while (bus.o_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", n < 2000, 1);
  endtask
  task automatic check_vec(input int v);
    logic [71:0] s = '0;
    foreach (tx_log[i]) if (i < 9) s[8*i+:8] = tx_log[i];
    check("tx_count", tx_log.size(), vecs[v].ntx);
    check("tx_stream", s, vecs[v].stream);
    check("rsp_count", rsp_w.size(), vecs[v].nrsp);
    check("rsp0", rsp_w.size() > 0 ? rsp_w[0] : 32'h0, vecs[v].rsp0);
    check("rsp1", rsp_w.size() > 1 ? rsp_w[1] : 32'h0, vecs[v].rsp1);
    foreach (rsp_i[k]) check("rsp_idx", rsp_i[k], k);
    check("pl_reads", pl_a.size(), vecs[v].txw);
    foreach (pl_a[k]) check("pl_addr", pl_a[k], k);
    check("done_pulses", done_cnt, 1);
    check("timeouts", to_cnt, 0);
    if (vecs[v].rxw == 0) check("done_latency", done_cyc - txd_cyc, 1);
  endtask
  task automatic load_vec(input int v);
    pl_mem[0] = vecs[v].pl0;
    pl_mem[1] = vecs[v].pl1;
    rx_src.delete();
    for (int i = 0; i < 4 * vecs[v].rxw; i++) rx_src.push_back(vecs[v].rxb[8*i+:8]);
  endtask
  logic [7:0] rc;
  int rtx, rrx, bad, k;
  initial begin
    vecs[0] = '{8'h4C, 2, 0, 32'h11223344, 32'hAABBCCDD, 64'h0, 9, 72'hAABBCCDD_11223344_4C, 0, 32'h0, 32'h0};
    vecs[1] = '{8'h52, 0, 2, 32'h0, 32'h0, 64'hDEADBEEF_12345678, 1, 72'h52, 2, 32'h12345678, 32'hDEADBEEF};
    vecs[2] = '{8'h53, 0, 0, 32'h0, 32'h0, 64'h0, 1, 72'h53, 0, 32'h0, 32'h0};
    vecs[3] = '{8'hA1, 1, 1, 32'hCAFEF00D, 32'h0, 64'h04030201, 5, 72'hCAFEF00D_A1, 1, 32'h04030201, 32'h0};
    vecs[4] = '{8'h7E, 2, 2, 32'h0, 32'hFFFFFFFF, 64'hFE017F80_00FF00FF, 9, 72'hFFFFFFFF_00000000_7E, 2,
                32'h00FF00FF, 32'hFE017F80};
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd = '0;
    bus.i_tx_words = '0;
    bus.i_rx_words = '0;
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.o_busy, 0);
    check("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_outputs", outs(), 0);
    for (int v = 0; v < 5; v++) begin
      load_vec(v);
      run_txn(vecs[v].cmd, vecs[v].txw, vecs[v].rxw, 0);
      check_vec(v);
    end
    load_vec(0);
    run_txn(vecs[0].cmd, vecs[0].txw, vecs[0].rxw, 1);
    check_vec(0);
    repeat (20) @(negedge clk);
    check("noise_not_queued", bus.o_busy, 0);
    issue(8'h54, 0, 1);
    wait_tx(1, 0);
    send_rx(8'h01, 2);
    send_rx(8'h02, 2);
    send_rx(8'h03, 2);
    k = 0;
    while (!bus.o_timeout && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("timeout_latency", k, TMO);
    check("timeout_busy_low", bus.o_busy, 0);
    @(negedge clk);
    check("timeout_pulse_width", bus.o_timeout, 0);
    check("timeout_pulses", to_cnt, 1);
    check("timeout_no_rsp", rsp_w.size(), 0);
    check("timeout_no_done", done_cnt, 0);
    load_vec(0);
    issue(8'h4C, 2, 0);
    k = 0;
    while (tx_log.size() < 5 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("reset_mid_wait", k < 2000, 1);
    #3 rst_n = 1'b0;
    #1 check("reset_mid_outputs", outs(), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_mid_no_done", done_cnt, 0);
    check("reset_mid_no_timeout", to_cnt, 0);
    check("reset_mid_idle", bus.o_busy, 0);
    run_txn(vecs[0].cmd, vecs[0].txw, vecs[0].rxw, 0);
    check_vec(0);
    for (int r = 0; r < 20; r++) begin
      rc = 8'($urandom);
      rtx = $urandom_range(0, 3);
      rrx = $urandom_range(0, 3);
      tx_lat = $urandom_range(1, 12);
      for (int i = 0; i < 4; i++) pl_mem[i] = $urandom;
      rx_src.delete();
      for (int i = 0; i < 4 * rrx; i++) rx_src.push_back(8'($urandom));
      exp_tx.delete();
      exp_tx.push_back(rc);
      for (int w = 0; w < rtx; w++) for (int b = 0; b < 4; b++) exp_tx.push_back(pl_mem[w][8*b+:8]);
      exp_rsp.delete();
      for (int w = 0; w < rrx; w++)
        exp_rsp.push_back({rx_src[4*w+3], rx_src[4*w+2], rx_src[4*w+1], rx_src[4*w]});
      run_txn(rc, rtx, rrx, 0);
      check("rnd_tx_count", tx_log.size(), exp_tx.size());
      bad = 0;
      foreach (exp_tx[i]) if (i >= tx_log.size() || tx_log[i] !== exp_tx[i]) bad++;
      check("rnd_tx_bytes", bad, 0);
      check("rnd_rsp_count", rsp_w.size(), exp_rsp.size());
      bad = 0;
      foreach (exp_rsp[i]) if (i >= rsp_w.size() || rsp_w[i] !== exp_rsp[i] || rsp_i[i] !== 10'(i)) bad++;
      check("rnd_rsp_words", bad, 0);
      check("rnd_done", done_cnt, 1);
    end
    check("tx_data_hold", hold_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
